// File: rtl/acp_stream_dma_ctrl.sv
// BRAM-to-HPS copy sequencer: CSR-programmed base/length, single-word Avalon-MM master writes
// over the FPGA-to-HPS ACP path, with busy/done/aborted status, progress count and irq.
module acp_stream_dma_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BRAM_AW = 10,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    // CSR slave
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    // BRAM read port
    output logic [BRAM_AW-1:0]  bram_address,
    input  logic [DATA_W-1:0]   bram_readdata,
    // Avalon-MM write master
    output logic [31:0]         avm_address,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic                avm_waitrequest,
    output logic                irq
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StWrite,
        StFinish
    } state_e;

    state_e state_q, state_d;

    logic [29:0]       base_q;
    logic [LEN_W-1:0]  len_q;
    logic              irq_en_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic              abort_pend_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [31:0]       cur_addr_q;

    logic csr_wr;
    logic start_req;
    logic abort_req;
    logic abort_now;
    logic ld_xfer;
    logic ld_empty;
    logic issue;
    logic accept;
    logic finish;

    assign csr_wr    = chipselect & ~write_n;
    // Abort in the same write as start wins, so start is only honoured without bit1.
    assign start_req = csr_wr && (address == 2'd2) && writedata[0] && !writedata[1];
    assign abort_req = csr_wr && (address == 2'd2) && writedata[1];
    assign abort_now = abort_pend_q | abort_req;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_req && (len_q != '0)) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = abort_now ? StFinish : StCapture;
            end
            StCapture: begin
                state_d = abort_now ? StFinish : StWrite;
            end
            StWrite: begin
                if (!avm_waitrequest) begin
                    state_d = ((remaining_q == LEN_W'(1)) || abort_now) ? StFinish : StFetch;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        ld_xfer  = 1'b0;
        ld_empty = 1'b0;
        issue    = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    ld_xfer  = (len_q != '0);
                    ld_empty = (len_q == '0);
                end
            end
            StCapture: issue  = !abort_now;
            StWrite:   accept = !avm_waitrequest;
            StFinish:  finish = 1'b1;
            default: ;
        endcase
    end

    // CSRs, status and transfer datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q        <= '0;
            len_q         <= '0;
            irq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            abort_pend_q  <= 1'b0;
            count_q       <= '0;
            remaining_q   <= '0;
            cur_addr_q    <= '0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            if (csr_wr && !busy_q) begin
                if (address == 2'd0) begin
                    base_q <= writedata[31:2];
                end
                if (address == 2'd1) begin
                    len_q <= writedata[LEN_W-1:0];
                end
            end
            if (csr_wr && (address == 2'd2)) begin
                irq_en_q <= writedata[2];
            end
            if (abort_req && busy_q && !finish) begin
                abort_pend_q <= 1'b1;
            end

            if (ld_xfer) begin
                cur_addr_q  <= {base_q, 2'b00};
                remaining_q <= len_q;
                count_q     <= '0;
                done_q      <= 1'b0;
                aborted_q   <= 1'b0;
                busy_q      <= 1'b1;
            end
            if (ld_empty) begin
                count_q   <= '0;
                done_q    <= 1'b1;
                aborted_q <= 1'b0;
            end
            if (issue) begin
                avm_writedata <= bram_readdata;
                avm_address   <= cur_addr_q;
                avm_write     <= 1'b1;
            end
            if (accept) begin
                count_q     <= count_q + LEN_W'(1);
                cur_addr_q  <= cur_addr_q + 32'd4;
                remaining_q <= remaining_q - LEN_W'(1);
                avm_write   <= 1'b0;
            end
            if (finish) begin
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                aborted_q    <= abort_pend_q;
                abort_pend_q <= 1'b0;
            end
        end
    end

    // BRAM index tracks progress, so it wraps naturally when LEN exceeds the BRAM depth.
    assign bram_address   = count_q[BRAM_AW-1:0];
    assign avm_byteenable = 4'hF;
    assign irq            = done_q & irq_en_q;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {base_q, 2'b00};
            2'd1:    readdata = 32'(len_q);
            2'd2:    readdata = {28'd0, aborted_q, irq_en_q, done_q, busy_q};
            default: readdata = 32'(count_q);
        endcase
    end

endmodule

// File: tb/tb_acp_stream_dma_ctrl.sv
// Scoreboard bench for acp_stream_dma_ctrl: expected master writes are queued by the stimulus
// and checked by an independent monitor on every accepted or stalled write.
module tb_acp_stream_dma_ctrl;

    localparam int unsigned BRAM_AW = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic [BRAM_AW-1:0] bram_address;
    logic [31:0]        bram_readdata;
    logic [31:0]        avm_address;
    logic               avm_write;
    logic [31:0]        avm_writedata;
    logic [3:0]         avm_byteenable;
    logic               avm_waitrequest;
    logic               irq;

    acp_stream_dma_ctrl #(
        .DATA_W (32),
        .BRAM_AW(BRAM_AW),
        .LEN_W  (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .bram_address   (bram_address),
        .bram_readdata  (bram_readdata),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] bram [4];
    always @(posedge clk) bram_readdata <= bram[bram_address];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   acc_cnt  = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input int gap);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: stalled writes must match the head entry; accepted writes pop it.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && avm_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_write: got write 0x%08h to 0x%08h, expected none",
                         avm_writedata, avm_address);
            end else if (avm_waitrequest) begin
                check("stall_addr", avm_address, exp_q[0].addr);
                check("stall_data", avm_writedata, exp_q[0].data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", avm_address, mon_e.addr);
                check("wr_data", avm_writedata, mon_e.data);
                check("wr_be", 32'(avm_byteenable), 32'hF);
                if (mon_e.gap != 0) check("wr_gap", 32'(cyc - last_acc), 32'(mon_e.gap));
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        csr_read(a, r);
        check(name, r, exp);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        bit          ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            csr_read(2'd2, s);
            if (!s[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_acc(input string name, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_acc"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_avm(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (avm_write) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_avm"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        address         = 2'd0;
        chipselect      = 1'b0;
        write_n         = 1'b1;
        writedata       = '0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) bram[i] = 32'hA0 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_addr", avm_address, 32'd0);
        check("rst_avm_data", avm_writedata, 32'd0);
        check("rst_bram_addr", 32'(bram_address), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Basic 4-word transfer, no stalls
        csr_write(2'd0, 32'h3000_0000);
        csr_write(2'd1, 32'd4);
        check_reg("t1_base", 2'd0, 32'h3000_0000);
        push(32'h3000_0000, 32'hA0, 0);
        push(32'h3000_0004, 32'hA1, 3);
        push(32'h3000_0008, 32'hA2, 3);
        push(32'h3000_000C, 32'hA3, 3);
        csr_write(2'd2, 32'h1);
        check_reg("t1_busy", 2'd2, 32'h1);
        @(posedge clk);
        #1;
        check("t1_lat2", 32'(avm_write), 32'd0);
        @(posedge clk);
        #1;
        check("t1_lat3", 32'(avm_write), 32'd1);
        wait_idle("t1");
        check_reg("t1_stat", 2'd2, 32'h2);
        check_reg("t1_count", 2'd3, 32'd4);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Same transfer with a 5-cycle stall on word 1
        push(32'h3000_0000, 32'hA0, 0);
        push(32'h3000_0004, 32'hA1, 8);
        push(32'h3000_0008, 32'hA2, 3);
        push(32'h3000_000C, 32'hA3, 3);
        csr_write(2'd2, 32'h1);
        wait_acc("t2", acc_cnt + 1);
        avm_waitrequest = 1'b1;
        wait_avm("t2");
        repeat (5) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle("t2");
        check_reg("t2_stat", 2'd2, 32'h2);
        check_reg("t2_count", 2'd3, 32'd4);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Abort while word 2 is stalled
        csr_write(2'd1, 32'd8);
        push(32'h3000_0000, 32'hA0, 0);
        push(32'h3000_0004, 32'hA1, 3);
        push(32'h3000_0008, 32'hA2, 0);
        csr_write(2'd2, 32'h1);
        wait_acc("t4", acc_cnt + 2);
        avm_waitrequest = 1'b1;
        wait_avm("t4");
        csr_write(2'd2, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle("t4");
        repeat (6) @(posedge clk);
        #1;
        check_reg("t4_stat", 2'd2, 32'hA);
        check_reg("t4_count", 2'd3, 32'd3);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length start: done next cycle, no writes, aborted cleared
        csr_write(2'd1, 32'd0);
        csr_write(2'd2, 32'h1);
        check_reg("t3_stat", 2'd2, 32'h2);
        check_reg("t3_count", 2'd3, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t3_no_write", 32'(avm_write), 32'd0);

        // Address wrap at 2^32 and BRAM index wrap at depth 4
        csr_write(2'd0, 32'hFFFF_FFF8);
        csr_write(2'd1, 32'd3);
        push(32'hFFFF_FFF8, 32'hA0, 0);
        push(32'hFFFF_FFFC, 32'hA1, 3);
        push(32'h0000_0000, 32'hA2, 3);
        csr_write(2'd2, 32'h1);
        wait_idle("t5a");
        check_reg("t5a_count", 2'd3, 32'd3);
        check("t5a_q_empty", 32'(exp_q.size()), 32'd0);
        csr_write(2'd1, 32'd5);
        push(32'hFFFF_FFF8, 32'hA0, 0);
        push(32'hFFFF_FFFC, 32'hA1, 3);
        push(32'h0000_0000, 32'hA2, 3);
        push(32'h0000_0004, 32'hA3, 3);
        push(32'h0000_0008, 32'hA0, 3);
        csr_write(2'd2, 32'h1);
        wait_idle("t5b");
        check_reg("t5b_count", 2'd3, 32'd5);
        check("t5b_q_empty", 32'(exp_q.size()), 32'd0);

        // Interrupt, then reset mid-WRITE
        csr_write(2'd1, 32'd2);
        push(32'hFFFF_FFF8, 32'hA0, 0);
        push(32'hFFFF_FFFC, 32'hA1, 3);
        csr_write(2'd2, 32'h5);
        check("t6_irq_busy", 32'(irq), 32'd0);
        check_reg("t6_stat_busy", 2'd2, 32'h5);
        wait_idle("t6");
        check("t6_irq_done", 32'(irq), 32'd1);
        check_reg("t6_stat_done", 2'd2, 32'h6);
        avm_waitrequest = 1'b1;
        push(32'hFFFF_FFF8, 32'hA0, 0);
        csr_write(2'd2, 32'h5);
        check("t6_irq_restart", 32'(irq), 32'd0);
        wait_avm("t6");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_avm_write", 32'(avm_write), 32'd0);
        check("t6_rst_irq", 32'(irq), 32'd0);
        check("t6_rst_avm_addr", avm_address, 32'd0);
        check("t6_rst_avm_data", avm_writedata, 32'd0);
        check("t6_rst_bram_addr", 32'(bram_address), 32'd0);
        for (int i = 0; i < 4; i++) check_reg("t6_rst_reg", 2'(i), 32'd0);
        exp_q.delete();
        avm_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_post_avm_write", 32'(avm_write), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
